// File: rtl/quad_gen.sv
// Quadrature generator: walks a shadow position toward a loaded target,
// emitting one complete A/B detent (00->..->00) per step on the shortest wrapped path.
module quad_gen #(
  parameter int unsigned WIDTH     = 14,
  parameter int unsigned PHASE_DIV = 1000
) (
  input  logic             clk_encod,
  input  logic             rst,
  input  logic [WIDTH-1:0] target,
  input  logic             load,
  output logic             rot_a,
  output logic             rot_b,
  output logic [WIDTH-1:0] position,
  output logic             busy,
  output logic             done
);

  localparam int unsigned TW = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(PHASE_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_P2,
    S_P3,
    S_P4
  } state_t;

  state_t           r_state;
  logic [TW-1:0]    r_timer;
  logic [WIDTH-1:0] r_target_q;
  logic [WIDTH-1:0] r_position;
  logic             r_dir_up;
  logic             r_arm;
  logic             r_a;
  logic             r_b;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_diff;
  logic             w_diff_nz;
  logic             w_up;
  logic             w_expired;
  logic [WIDTH-1:0] w_step;

  // Shortest path with wrap: MSB of the modular difference selects DN.
  assign w_diff    = r_target_q - r_position;
  assign w_diff_nz = |w_diff;
  assign w_up      = ~w_diff[WIDTH-1];
  assign w_expired = (r_timer == '0);
  assign w_step    = r_dir_up ? WIDTH'(1) : {WIDTH{1'b1}};

  // r_arm adds one idle cycle so AB leaves 00 two edges after the load edge.
  always_ff @(posedge clk_encod or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_target_q <= '0;
      r_position <= '0;
      r_dir_up   <= 1'b0;
      r_arm      <= 1'b0;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) r_target_q <= target;

      case (r_state)
        S_IDLE: begin
          if (r_arm && w_diff_nz) begin
            r_state      <= S_P1;
            r_dir_up     <= w_up;
            {r_a, r_b}   <= w_up ? 2'b10 : 2'b01;
            r_busy       <= 1'b1;
            r_arm        <= 1'b0;
            r_timer      <= TMAX;
          end else begin
            r_arm <= w_diff_nz;
          end
        end

        S_P1: begin
          if (w_expired) begin
            r_state    <= S_P2;
            {r_a, r_b} <= 2'b11;
            r_timer    <= TMAX;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        S_P2: begin
          if (w_expired) begin
            r_state    <= S_P3;
            {r_a, r_b} <= r_dir_up ? 2'b01 : 2'b10;
            r_timer    <= TMAX;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        // Returning to 00 completes the detent, so the shadow count moves here.
        S_P3: begin
          if (w_expired) begin
            r_state    <= S_P4;
            {r_a, r_b} <= 2'b00;
            r_position <= r_position + w_step;
            r_timer    <= TMAX;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        S_P4: begin
          if (w_expired) begin
            if (w_diff_nz) begin
              r_state    <= S_P1;
              r_dir_up   <= w_up;
              {r_a, r_b} <= w_up ? 2'b10 : 2'b01;
              r_timer    <= TMAX;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_timer <= '0;
            end
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rot_a    = r_a;
  assign rot_b    = r_b;
  assign position = r_position;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_quad_gen.sv
// Bench for quad_gen: a decoder-style model watches A/B every cycle, plus
// directed detent scenarios with hand-computed expectations and random loads.
module tb_quad_gen;

  localparam int W  = 14;
  localparam int PD = 4;

  logic         clk_encod = 1'b0;
  logic         rst       = 1'b1;
  logic         load      = 1'b0;
  logic [W-1:0] target    = '0;
  logic         rot_a;
  logic         rot_b;
  logic [W-1:0] position;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;

  quad_gen #(.WIDTH(W), .PHASE_DIV(PD)) dut (
    .clk_encod (clk_encod),
    .rst       (rst),
    .target    (target),
    .load      (load),
    .rot_a     (rot_a),
    .rot_b     (rot_b),
    .position  (position),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_encod = ~clk_encod;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Requested target as the design must hold it, and its value one edge earlier.
  logic [W-1:0] m_tq;
  logic [W-1:0] m_tq_old;
  always @(posedge clk_encod or posedge rst) begin
    if (rst) begin
      m_tq     <= '0;
      m_tq_old <= '0;
    end else begin
      m_tq_old <= m_tq;
      if (load) m_tq <= target;
    end
  end

  // Decoder-level model of the A/B stream, sampled 1 time unit after each edge.
  logic [1:0]   prev_ab;
  logic [1:0]   mon_ab;
  logic [1:0]   exp_ab;
  logic [5:0]   seqv;
  int           seq_len;
  int           run_len;
  int           idle_streak;
  int           done_cnt = 0;
  logic         prev_busy;
  logic [W-1:0] dec;
  logic [W-1:0] mdiff;

  initial forever begin
    @(posedge clk_encod);
    #1;
    if (rst) begin
      prev_ab = 2'b00; seqv = '0; seq_len = 0; run_len = 0;
      idle_streak = 0; prev_busy = 1'b0; dec = '0;
    end else begin
      mon_ab = {rot_a, rot_b};
      if (mon_ab != prev_ab) begin
        chk($countones(mon_ab ^ prev_ab) == 1, "ab_one_bit", int'(mon_ab), int'(prev_ab));
        if (prev_ab != 2'b00) chk(run_len == PD, "phase_len", run_len, PD);
        else if (prev_busy) chk(run_len == PD, "p4_len", run_len, PD);
        if (prev_ab == 2'b00) begin
          mdiff  = m_tq_old - position;
          exp_ab = mdiff[W-1] ? 2'b01 : 2'b10;
          chk(mdiff != '0, "start_needed", int'(mdiff), 1);
          chk(mon_ab == exp_ab, "start_dir", int'(mon_ab), int'(exp_ab));
        end
        if (mon_ab == 2'b00) begin
          if (seq_len == 3 && seqv == 6'b10_11_01) dec = dec + W'(1);
          else if (seq_len == 3 && seqv == 6'b01_11_10) dec = dec - W'(1);
          seqv = '0;
          seq_len = 0;
        end else begin
          seqv = {seqv[3:0], mon_ab};
          seq_len++;
        end
        run_len = 1;
      end else begin
        run_len++;
      end

      chk(position == dec, "pos_vs_decoder", int'(position), int'(dec));
      if (mon_ab != 2'b00) chk(busy, "busy_in_detent", int'(busy), 1);
      if (done) begin
        done_cnt++;
        chk(mon_ab == 2'b00 && run_len == PD + 1, "done_timing", run_len, PD + 1);
        chk(position == m_tq_old, "done_at_target", int'(position), int'(m_tq_old));
        chk(!busy && prev_busy, "done_busy_edge", int'({prev_busy, busy}), 2);
      end
      if (prev_busy && !busy) chk(done, "busy_fall_done", int'(done), 1);
      if (!busy && m_tq != position) idle_streak++;
      else idle_streak = 0;
      if (!busy) chk(idle_streak <= 3, "idle_stall", idle_streak, 3);
      prev_ab   = mon_ab;
      prev_busy = busy;
    end
  end

  task automatic tick();
    @(posedge clk_encod);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk_encod);
    rst = 1'b1;
    @(negedge clk_encod);
    @(negedge clk_encod);
    rst = 1'b0;
    tick();
  endtask

  // Load is sampled on the next edge; returns at the first sample after it.
  task automatic do_load(input logic [W-1:0] v);
    @(negedge clk_encod);
    target = v;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  int         r_first;
  logic [1:0] r_first_ab;
  int         r_done_idx;
  int         pos_seen[$];

  task automatic run_to_done(input int budget);
    logic [W-1:0] last;
    r_first = -1; r_first_ab = 2'b00; r_done_idx = -1;
    pos_seen.delete();
    last = position;
    for (int i = 0; i <= budget; i++) begin
      if (i > 0) tick();
      if (r_first < 0 && {rot_a, rot_b} != 2'b00) begin
        r_first    = i;
        r_first_ab = {rot_a, rot_b};
      end
      if (position != last) begin
        pos_seen.push_back(int'(position));
        last = position;
      end
      if (done) begin
        r_done_idx = i;
        break;
      end
    end
    chk(r_done_idx >= 0, "done_timeout", r_done_idx, budget);
  endtask

  task automatic wait_start(input string name, input int budget);
    int i;
    for (i = 0; i < budget && {rot_a, rot_b} == 2'b00; i++) tick();
    chk(i < budget, name, i, budget);
  endtask

  task automatic check_pos(input string name, input int n, input int e0, input int e1, input int e2);
    int ev[3];
    int got;
    ev[0] = e0; ev[1] = e1; ev[2] = e2;
    chk(pos_seen.size() == n, {name, "_count"}, pos_seen.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (i < pos_seen.size()) ? pos_seen[i] : -1;
      chk(got == ev[i], {name, "_value"}, got, ev[i]);
    end
  endtask

  int           snap;
  int           settled;
  int           d;
  bit           any_busy;
  logic [W-1:0] last_tgt;

  initial begin
    do_reset();
    chk({rot_a, rot_b} == 2'b00, "reset_ab", int'({rot_a, rot_b}), 0);
    chk(position == '0, "reset_pos", int'(position), 0);
    chk(!busy && !done, "reset_busy_done", int'({busy, done}), 0);

    // Three UP detents: first 10, positions 1,2,3, done 48 clocks after P1 entry.
    snap = done_cnt;
    do_load(W'(3));
    run_to_done(100);
    chk(r_first == 2, "t2_latency", r_first, 2);
    chk(r_first_ab == 2'b10, "t2_dir", int'(r_first_ab), 2);
    chk(r_done_idx - r_first == 48, "t2_done_time", r_done_idx - r_first, 48);
    check_pos("t2_pos", 3, 1, 2, 3);
    repeat (4) tick();
    chk(done_cnt - snap == 1, "t2_done_once", done_cnt - snap, 1);

    // Wrap downward: 0 -> 16383 -> 16382.
    do_reset();
    snap = done_cnt;
    do_load(W'(16382));
    run_to_done(100);
    chk(r_first_ab == 2'b01, "t3_dir", int'(r_first_ab), 1);
    check_pos("t3_pos", 2, 16383, 16382, 0);
    repeat (4) tick();
    chk(done_cnt - snap == 1, "t3_done_once", done_cnt - snap, 1);

    // Half-range tie goes DN; one less goes UP. Retarget so the detent ends the run.
    do_reset();
    do_load(W'(8192));
    wait_start("t4a_start", 10);
    chk({rot_a, rot_b} == 2'b01, "t4a_dir", int'({rot_a, rot_b}), 1);
    do_load(W'(16383));
    run_to_done(100);
    chk(position == W'(16383), "t4a_pos", int'(position), 16383);
    do_reset();
    do_load(W'(8191));
    wait_start("t4b_start", 10);
    chk({rot_a, rot_b} == 2'b10, "t4b_dir", int'({rot_a, rot_b}), 2);
    do_load(W'(1));
    run_to_done(100);
    chk(position == W'(1), "t4b_pos", int'(position), 1);

    // Retarget during P2 of the second detent: it completes, then reverses.
    do_reset();
    snap = done_cnt;
    do_load(W'(5));
    settled = 0;
    for (int i = 0; i < 100; i++) begin
      if (position == W'(1) && {rot_a, rot_b} == 2'b11) begin
        settled = 1;
        break;
      end
      tick();
    end
    chk(settled == 1, "t5_reach_p2", settled, 1);
    chk(done_cnt == snap, "t5_no_early_done", done_cnt - snap, 0);
    do_load(W'(0));
    run_to_done(200);
    check_pos("t5_pos", 3, 2, 1, 0);
    repeat (4) tick();
    chk(done_cnt - snap == 1, "t5_done_once", done_cnt - snap, 1);

    // Asynchronous reset mid-detent, checked before the next clock edge.
    do_reset();
    do_load(W'(100));
    repeat (22) tick();
    #1;
    rst = 1'b1;
    #1;
    chk({rot_a, rot_b} == 2'b00, "t1_async_ab", int'({rot_a, rot_b}), 0);
    chk(position == '0, "t1_async_pos", int'(position), 0);
    chk(!busy && !done, "t1_async_busy_done", int'({busy, done}), 0);
    @(negedge clk_encod);
    @(negedge clk_encod);
    rst = 1'b0;
    tick();

    // Random small retargets at random times, including around wrap.
    last_tgt = '0;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 30)) tick();
      d = int'($urandom_range(0, 12)) - 6;
      last_tgt = W'(int'(position) + d);
      do_load(last_tgt);
    end
    settled = 0;
    for (int i = 0; i < 6000 && settled < 3; i++) begin
      tick();
      if (!busy && position == last_tgt) settled++;
      else settled = 0;
    end
    chk(settled == 3, "t6_settle", int'(position), int'(last_tgt));

    // Loading the current position while idle does nothing.
    snap = done_cnt;
    any_busy = 1'b0;
    do_load(position);
    repeat (12) begin
      tick();
      any_busy |= busy;
    end
    chk(!any_busy, "noop_busy", int'(any_busy), 0);
    chk(done_cnt == snap, "noop_done", done_cnt - snap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
